// File: rtl/coin_refund.sv
// Coin refund sequencer: pays out a latched credit with a greedy coin choice,
// one coin per eject/ack handshake, with an ack timeout that parks in ERROR.
module coin_refund #(
  parameter int VAL_A       = 5,
  parameter int VAL_B       = 15,
  parameter int VAL_C       = 25,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [6:0] balance,
  input  logic       ack,
  output logic       eject_a,
  output logic       eject_b,
  output logic       eject_c,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] remaining,
  output logic [3:0] coin_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_SELECT  = 3'd2;
  localparam logic [2:0] S_EJECT   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [6:0] LV_A = 7'(VAL_A);
  localparam logic [6:0] LV_B = 7'(VAL_B);
  localparam logic [6:0] LV_C = 7'(VAL_C);

  logic [2:0]    r_state;
  logic [6:0]    r_rem;
  logic [3:0]    r_cnt;
  logic [2:0]    r_ej;     // {c, b, a}
  logic [6:0]    r_val;
  logic [CW-1:0] r_tmo;

  logic w_tmo_hit;
  logic w_bad_bal;

  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign w_bad_bal = (r_rem > 7'd70) || ((r_rem % 7'd5) != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_ej    <= '0;
      r_val   <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_rem   <= balance;
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad_bal)          r_state <= S_ERROR;
          else if (r_rem == 7'd0) r_state <= S_DONE;
          else                    r_state <= S_SELECT;
        end
        S_SELECT: begin
          r_tmo <= '0;
          if (r_rem >= LV_C) begin
            r_ej <= 3'b100; r_val <= LV_C; r_state <= S_EJECT;
          end else if (r_rem >= LV_B) begin
            r_ej <= 3'b010; r_val <= LV_B; r_state <= S_EJECT;
          end else if (r_rem >= LV_A) begin
            r_ej <= 3'b001; r_val <= LV_A; r_state <= S_EJECT;
          end else begin
            // no coin fits: only reachable with non-multiple coin parameters
            r_ej <= 3'b000; r_state <= S_ERROR;
          end
        end
        S_EJECT: begin
          if (ack) begin
            r_rem   <= r_rem - r_val;
            r_cnt   <= (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
            r_ej    <= '0;
            r_tmo   <= '0;
            r_state <= S_RELEASE;
          end else if (w_tmo_hit) begin
            r_ej    <= '0;
            r_state <= S_ERROR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!ack)           r_state <= (r_rem == 7'd0) ? S_DONE : S_SELECT;
          else if (w_tmo_hit) r_state <= S_ERROR;
          else                r_tmo   <= r_tmo + 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: if (!req) r_state <= S_IDLE;
        default: begin
          r_ej    <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eject_a   = r_ej[0];
  assign eject_b   = r_ej[1];
  assign eject_c   = r_ej[2];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERROR);
  assign remaining = r_rem;
  assign coin_cnt  = r_cnt;

endmodule
